// File: rtl/deserializer_ext.sv
// -----------------------------------------------------------------------------
// deserializer_ext
//
// Parametrised serial-to-parallel converter. Serial bits arrive one per
// data_val_i strobe and are packed into a DATA_W-bit word, either MSB-first
// (LSB_FIRST=0) or LSB-first (LSB_FIRST=1). A word is emitted when it fills
// up, or earlier as a partial word when flush_i is raised. The output side
// is a single-entry valid/ready register. A word that completes while that
// register is still occupied is dropped and reported on overflow_o.
//
// Ports:
//   clk_i              - clock, all logic on the rising edge
//   rst_n_i            - asynchronous active-low reset
//   data_i             - serial data bit
//   data_val_i         - data_i is valid this cycle
//   flush_i            - emit the partially assembled word
//   deser_data_o       - assembled word
//   deser_bits_o       - number of valid bits in deser_data_o (1..DATA_W)
//   deser_data_val_o   - output word valid
//   deser_data_ready_i - consumer accepts the word this cycle
//   overflow_o         - one-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module deserializer_ext #(
  parameter int DATA_W    = 16,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_bits_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i,
  output logic              overflow_o
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE_LSB  = DATA_W'(1);
  localparam logic [DATA_W-1:0] ONE_MSB  = ONE_LSB << (DATA_W - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    bits_q;
  logic                val_q;
  logic                overflow_q;

  logic [CNT_W-1:0]    cnt_cur;
  logic [DATA_W-1:0]   bit_mask;
  logic [DATA_W-1:0]   word_next;
  logic [CNT_W-1:0]    bits_next;
  logic                word_full;
  logic                flush_ev;
  logic                complete;
  logic                out_free;

  // Next-word assembly. The bit accepted this cycle is merged in before the
  // completion decision, so a bit arriving together with flush_i (or as the
  // last bit of a word) is part of the emitted word. IDLE pins the count
  // base to zero so the first bit always lands at the first position.
  always_comb begin
    cnt_cur   = (state_q == IDLE) ? '0 : cnt_q;
    bit_mask  = LSB_FIRST ? (ONE_LSB << cnt_cur) : (ONE_MSB >> cnt_cur);
    word_next = shift_q;
    if (data_val_i && data_i) begin
      word_next = shift_q | bit_mask;
    end
    bits_next = cnt_cur + CNT_W'(data_val_i);
    word_full = data_val_i && (cnt_cur == LAST_IDX);
    flush_ev  = flush_i && (bits_next != '0);
    complete  = word_full || flush_ev;
    // The output register can take a new word if it is empty or its
    // current word is leaving this very cycle (no bubble on back-to-back).
    out_free  = !val_q || deser_data_ready_i;
  end

  // Collection FSM and output register. On completion the collector always
  // clears; the word either moves to the output register or, if that is
  // still occupied, is dropped with a single-cycle overflow pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      bits_q     <= '0;
      val_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (val_q && deser_data_ready_i) begin
        val_q <= 1'b0;
      end
      if (complete) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        shift_q <= '0;
        if (out_free) begin
          data_q <= word_next;
          bits_q <= bits_next;
          val_q  <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else begin
        cnt_q   <= bits_next;
        shift_q <= word_next;
        if (data_val_i) begin
          state_q <= COLLECT;
        end
      end
    end
  end

  assign deser_data_o     = data_q;
  assign deser_bits_o     = bits_q;
  assign deser_data_val_o = val_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_deserializer_ext.sv
// -----------------------------------------------------------------------------
// tb_deserializer_ext
//
// Drives one shared stimulus stream into an MSB-first and an LSB-first
// 16-bit deserializer_ext. A bit-queue model of the converter predicts the
// output register of both instances; a negedge process compares every
// output every cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_deserializer_ext;

  localparam int DW = 16;
  localparam int CW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data = 1'b0;
  logic dval = 1'b0;
  logic flush = 1'b0;
  logic ready = 1'b1;

  logic [DW-1:0] m_data, l_data;
  logic [CW-1:0] m_bits, l_bits;
  logic          m_val, l_val, m_ovf, l_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deserializer_ext #(.DATA_W(DW), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .data_val_i(dval),
    .flush_i(flush), .deser_data_o(m_data), .deser_bits_o(m_bits),
    .deser_data_val_o(m_val), .deser_data_ready_i(ready), .overflow_o(m_ovf)
  );

  deserializer_ext #(.DATA_W(DW), .LSB_FIRST(1'b1)) dut_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .data_val_i(dval),
    .flush_i(flush), .deser_data_o(l_data), .deser_bits_o(l_bits),
    .deser_data_val_o(l_val), .deser_data_ready_i(ready), .overflow_o(l_ovf)
  );

  // Reference model: received bits are kept as a plain list in arrival
  // order; a word is built from that list only when it is emitted.
  bit            rx_q[$];
  logic [DW-1:0] exp_msb = '0;
  logic [DW-1:0] exp_lsb = '0;
  logic [CW-1:0] exp_bits = '0;
  logic          exp_val = 1'b0;
  logic          exp_ovf = 1'b0;
  bit            mdl_free;
  bit            mdl_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      exp_msb  = '0;
      exp_lsb  = '0;
      exp_bits = '0;
      exp_val  = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      mdl_free = !exp_val || ready;
      exp_ovf  = 1'b0;
      if (dval) rx_q.push_back(data);
      mdl_done = (rx_q.size() == DW) || (flush && rx_q.size() > 0);
      if (exp_val && ready) exp_val = 1'b0;
      if (mdl_done) begin
        if (mdl_free) begin
          exp_val  = 1'b1;
          exp_bits = CW'(rx_q.size());
          exp_msb  = '0;
          exp_lsb  = '0;
          for (int k = 0; k < rx_q.size(); k++) begin
            exp_msb[DW-1-k] = rx_q[k];
            exp_lsb[k]      = rx_q[k];
          end
        end else begin
          exp_ovf = 1'b1;
        end
        rx_q.delete();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("msb_data", m_data, exp_msb);
    checkOutput("msb_bits", m_bits, exp_bits);
    checkOutput("msb_val",  m_val,  exp_val);
    checkOutput("msb_ovf",  m_ovf,  exp_ovf);
    checkOutput("lsb_data", l_data, exp_lsb);
    checkOutput("lsb_bits", l_bits, exp_bits);
    checkOutput("lsb_val",  l_val,  exp_val);
    checkOutput("lsb_ovf",  l_ovf,  exp_ovf);
  end

  // One cycle of stimulus, applied just after the falling edge.
  task automatic applyStimulus(input logic d, input logic v, input logic f,
                               input logic r);
    @(negedge clk);
    data  = d;
    dval  = v;
    flush = f;
    ready = r;
  endtask

  // Sends the first n bits of w, most significant first, with optional
  // random idle gaps of 0..max_gap cycles before each bit.
  task automatic sendBits(input logic [DW-1:0] w, input int n, input int max_gap);
    logic [DW-1:0] tmp;
    tmp = w;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) applyStimulus(1'b0, 1'b0, 1'b0, ready);
      end
      applyStimulus(tmp[DW-1-i], 1'b1, 1'b0, ready);
    end
  endtask

  task automatic asyncResetCheck(input string tag);
    @(negedge clk);
    data = 1'b0; dval = 1'b0; flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_msb_data"}, m_data, 0);
    checkOutput({tag, "_msb_val"},  m_val,  0);
    checkOutput({tag, "_msb_bits"}, m_bits, 0);
    checkOutput({tag, "_lsb_data"}, l_data, 0);
    checkOutput({tag, "_lsb_val"},  l_val,  0);
    checkOutput({tag, "_ovf"},      m_ovf | l_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    checkOutput("rst_msb_data", m_data, 0);
    checkOutput("rst_val", m_val | l_val, 0);
    checkOutput("rst_bits", m_bits, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full word, contiguous, ready high
    ready = 1'b1;
    sendBits(16'hB0F1, 16, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full_msb_data", m_data, 16'hB0F1);
    checkOutput("full_lsb_data", l_data, 16'h8F0D);
    checkOutput("full_bits", m_bits, 16);
    checkOutput("full_val", m_val, 1);
    checkOutput("model_msb", exp_msb, 16'hB0F1);
    checkOutput("model_lsb", exp_lsb, 16'h8F0D);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full_val_drop", m_val, 0);

    // Same bits with random gaps
    sendBits(16'hB0F1, 16, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("gap_msb_data", m_data, 16'hB0F1);
    checkOutput("gap_lsb_data", l_data, 16'h8F0D);
    checkOutput("gap_val", l_val, 1);

    // Partial word: five bits, flush with the fifth
    sendBits(16'hD000, 4, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_msb_data", m_data, 16'hD000);
    checkOutput("flush_lsb_data", l_data, 16'h000B);
    checkOutput("flush_bits", m_bits, 5);
    checkOutput("model_flush_bits", exp_bits, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_flush_val", m_val, 0);

    // Overflow: A held, B dropped
    ready = 1'b0;
    sendBits(16'h1234, 16, 0);
    sendBits(16'hABCD, 16, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pulse", m_ovf, 1);
    checkOutput("ovf_held", m_data, 16'h1234);
    checkOutput("ovf_val", m_val, 1);
    checkOutput("model_ovf", exp_ovf, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_once", m_ovf, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_drained", m_val, 0);

    // Back-to-back: C completes in the cycle A is accepted
    sendBits(16'h1234, 16, 0);
    sendBits(16'h5A5A, 15, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_val", m_val, 1);
    checkOutput("b2b_data", m_data, 16'h5A5A);
    checkOutput("b2b_ovf", m_ovf, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-word and while a word is held
    ready = 1'b0;
    sendBits(16'hFFFF, 16, 0);
    sendBits(16'hFF00, 8, 0);
    asyncResetCheck("arst");
    ready = 1'b1;
    sendBits(16'hC3A5, 16, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_data", m_data, 16'hC3A5);
    checkOutput("post_rst_bits", m_bits, 16);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializer_ext.md
Name: deserializer_ext

Overview:
Parametrised serial-to-parallel converter. It is the successor to the fixed 16-bit deserializer. It adds configurable word width, selectable bit order, partial-word flush, and a valid/ready output handshake with overflow reporting. It sits between a serial bit source (one bit per strobe) and a word-wide consumer that may stall.

Parameters:
DATA_W, 16, output word width in bits; legal range 2..64.
LSB_FIRST, 0, bit order: 0 = first received bit lands at bit DATA_W-1; 1 = first received bit lands at bit 0.
CNT_W, $clog2(DATA_W)+1, derived width of bit counter and deser_bits_o; not to be overridden.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_n_i  input  1  reset, asynchronous assert, active-low.
data_i  input  1  serial data bit.
data_val_i  input  1  data_i is valid this cycle.
flush_i  input  1  emit the partially assembled word.
deser_data_o  output  DATA_W  assembled word.
deser_bits_o  output  CNT_W  number of valid bits in deser_data_o (1..DATA_W).
deser_data_val_o  output  1  output word valid.
deser_data_ready_i  input  1  consumer accepts the word this cycle.
overflow_o  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (rst_n_i=0, asynchronous): FSM -> IDLE, bit counter = 0, shift buffer = 0, deser_data_o = 0, deser_bits_o = 0, deser_data_val_o = 0, overflow_o = 0. Deassertion is synchronous to clk_i, as provided externally.
- FSM states:
  - IDLE: counter = 0. On data_val_i, go to COLLECT.
  - COLLECT: counter > 0. On word completion (counter reaches DATA_W) or flush, go to IDLE.
- Bit placement: the k-th accepted bit (k = 0 first) is written to buffer index DATA_W-1-k when LSB_FIRST=0, and to index k when LSB_FIRST=1. Bit positions not yet filled read 0.
- Completion event, in the same cycle as the qualifying input:
  - (a) data_val_i=1 and counter = DATA_W-1 (full word, bits = DATA_W), or
  - (b) flush_i=1 and (counter + data_val_i) > 0 (partial word, bits = counter + data_val_i).
- On a completion event: the assembled word, including any bit accepted this cycle, and its bit count are transferred to the output register. The counter and buffer clear. If data_val_i and flush_i are both high, the bit is accepted first and then flushed.
- flush_i with counter = 0 and data_val_i = 0 is ignored; no output.
- Latency: deser_data_val_o rises on the clock edge after the cycle carrying the final bit or flush, i.e. 1 cycle.
- Output handshake:
  - A word transfers when deser_data_val_o && deser_data_ready_i.
  - While valid and not ready, deser_data_o, deser_bits_o and deser_data_val_o hold stable.
  - The output register is free when !deser_data_val_o, or when a transfer occurs this cycle. A completion event in the transfer cycle loads the new word with valid kept at 1; there are no bubbles.
- Overflow: a completion event while the output register is not free drops the new word. The held word is kept, overflow_o pulses high for exactly 1 cycle, and the counter and buffer still clear.
- Input is never back-pressured. data_val_i=0 cycles are gaps; the counter holds and there is no timeout.
- deser_data_ready_i is ignored while deser_data_val_o = 0.
- Counter width CNT_W: it never exceeds DATA_W and never wraps.

Test Plan:
- DATA_W=16, LSB_FIRST=0, ready=1: feed 16 contiguous bits 1,0,1,1,0,0,0,0,1,1,1,1,0,0,0,1 -> one cycle after the 16th bit, deser_data_o=16'hB0F1, deser_bits_o=16, valid for 1 cycle.
- Same bits with LSB_FIRST=1 -> deser_data_o=16'h8F0D; then repeat with random data_val_i gaps of 0..3 cycles -> identical result.
- DATA_W=16, MSB-first: feed 5 bits 1,1,0,1,0, then flush_i in the cycle of the 5th bit -> deser_data_o=16'hD000, deser_bits_o=5; a second flush with no bits -> no output.
- ready=0: complete word A=16'h1234, then word B -> A held stable, overflow_o pulses once when B completes, B lost; raise ready -> A transfers, valid drops.
- ready toggling: word C completes in the same cycle A is accepted -> valid stays 1, C presented the next cycle, no overflow.
- Assert rst_n_i low asynchronously mid-word (8 bits in) and while valid=1 -> all outputs 0 immediately, without waiting for an edge; after release, a fresh 16-bit word assembles correctly from bit 0.
